// File: rtl/spi_ram_sp.sv
// Purpose : single-port 8-bit RAM executing 10-bit SPI command words (address/data, write/read).
// Latency : writes commit on the rx_valid edge; dout/tx_valid register on that edge, visible next cycle.
// Backpressure: none; every rx_valid cycle executes one command, and tx_valid holds until the next command.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   rx_din[9:0]       [9:8] command, [7:0] payload
//   rx_valid          one command per cycle high
//   dout[7:0]         read data to the SPI slave
//   tx_valid          dout valid, cleared by any accepted non-RD_DATA command
//   seq_err           sticky, set when a data command arrives before its address
// Configuration: define ADDR_AUTOINC_EN to post-increment (with wrap) the write/read
//   address after each successful WR_DATA / RD_DATA.
module spi_ram_sp #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       seq_err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(MEM_DEPTH);

  // State bit 0 = write address seen, bit 1 = read address seen.
  typedef enum logic [1:0] {
    NO_ADDR  = 2'b00,
    WR_READY = 2'b01,
    RD_READY = 2'b10,
    BOTH     = 2'b11
  } state_t;

  state_t state, state_n;
  logic   wr_ok, rd_ok;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] addr_pl;
  logic                 wr_in_range, rd_in_range;
  logic                 wr_addr_cmd, rd_addr_cmd;
  logic                 wr_en;

  assign cmd         = rx_din[9:8];
  assign addr_pl     = rx_din[ADDR_SIZE-1:0];
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_addr_cmd = rx_valid && (cmd == CMD_WR_ADDR);
  assign rd_addr_cmd = rx_valid && (cmd == CMD_RD_ADDR);

`ifdef ADDR_AUTOINC_EN
  // Wrap to 0 after the last valid location (also recovers out-of-range addresses).
  function automatic logic [ADDR_SIZE-1:0] inc_addr(input logic [ADDR_SIZE-1:0] a);
    if ({1'b0, a} >= DEPTH_L - 1'b1) return '0;
    else return a + ADDR_SIZE'(1);
  endfunction
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NO_ADDR;
    else     state <= state_n;
  end

  // FSM: next state; an address command only ever adds its own flag.
  always_comb begin
    state_n = state;
    case (state)
      NO_ADDR: begin
        if (wr_addr_cmd)      state_n = WR_READY;
        else if (rd_addr_cmd) state_n = RD_READY;
      end
      WR_READY: if (rd_addr_cmd) state_n = BOTH;
      RD_READY: if (wr_addr_cmd) state_n = BOTH;
      BOTH:     state_n = BOTH;
      default:  state_n = NO_ADDR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    case (state)
      WR_READY: wr_ok = 1'b1;
      RD_READY: rd_ok = 1'b1;
      BOTH: begin
        wr_ok = 1'b1;
        rd_ok = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_en = rx_valid && (cmd == CMD_WR_DATA) && wr_ok && wr_in_range;

  // Array has no reset; the !rst term blocks a write on an edge that coincides with reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= rx_din[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
      seq_err  <= 1'b0;
    end else if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          wr_addr  <= addr_pl;
          tx_valid <= 1'b0;
        end
        CMD_WR_DATA: begin
          tx_valid <= 1'b0;
          if (wr_ok) begin
`ifdef ADDR_AUTOINC_EN
            wr_addr <= inc_addr(wr_addr);
`endif
          end else begin
            seq_err <= 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr  <= addr_pl;
          tx_valid <= 1'b0;
        end
        default: begin // RD_DATA: a rejected read leaves dout/tx_valid untouched
          if (rd_ok) begin
            dout     <= rd_in_range ? mem[rd_addr] : 8'h00;
            tx_valid <= 1'b1;
`ifdef ADDR_AUTOINC_EN
            rd_addr  <= inc_addr(rd_addr);
`endif
          end else begin
            seq_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_sp.sv
module tb_spi_ram_sp;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] rx_din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       seq_err;

  int vectors = 0;
  int errors  = 0;

  // Reference model: command semantics only.
  logic [7:0] mem_m [DEPTH];
  int         wa_m, ra_m;
  bit         wok_m, rok_m, txv_m, seq_m;
  logic [7:0] dout_m;

  spi_ram_sp #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_din   (rx_din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  function automatic int next_addr(input int a);
`ifdef ADDR_AUTOINC_EN
    return (a + 1) % DEPTH;
`else
    return a;
`endif
  endfunction

  task automatic model_reset();
    wa_m = 0; ra_m = 0; wok_m = 0; rok_m = 0;
    txv_m = 0; seq_m = 0; dout_m = 8'h00;
  endtask

  task automatic model_apply(input logic [1:0] c, input logic [7:0] pl);
    case (c)
      2'b00: begin wa_m = int'(pl); wok_m = 1; txv_m = 0; end
      2'b01: begin
        txv_m = 0;
        if (wok_m) begin
          if (wa_m < DEPTH) mem_m[wa_m] = pl;
          wa_m = next_addr(wa_m);
        end else seq_m = 1;
      end
      2'b10: begin ra_m = int'(pl); rok_m = 1; txv_m = 0; end
      default: begin
        if (rok_m) begin
          dout_m = (ra_m < DEPTH) ? mem_m[ra_m] : 8'h00;
          txv_m  = 1;
          ra_m   = next_addr(ra_m);
        end else seq_m = 1;
      end
    endcase
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check8({tag, ".dout"},     dout,            dout_m);
    check8({tag, ".tx_valid"}, {7'd0, tx_valid}, {7'd0, txv_m});
    check8({tag, ".seq_err"},  {7'd0, seq_err},  {7'd0, seq_m});
  endtask

  // Drive a command for n consecutive cycles; inputs change on negedge only.
  task automatic strobe(input logic [1:0] c, input logic [7:0] pl, input int n);
    @(negedge clk);
    rx_din   = {c, pl};
    rx_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_apply(c, pl);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] pl);
    strobe(c, pl, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] c;
    logic [7:0] pl;
    int         n;

    do_reset();
    check_all("reset");

    // Data command before any address: rejected, flagged.
    send(2'b01, 8'h3C);
    check_all("early_wr_data");
    check8("early_wr_data.seq_set", {7'd0, seq_err}, 8'h01);

    // Give every location a known value.
    for (int a = 0; a < DEPTH; a++) begin
      send(2'b00, 8'(a));
      send(2'b01, 8'($urandom_range(0, 255)));
    end
    send(2'b00, 8'h00);
    send(2'b01, 8'h00);

    // Basic write then read of 0x12.
    send(2'b00, 8'h12);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    check_all("rd_0x12");
    check8("rd_0x12.const", dout, 8'hA5);

    // Address command clears tx_valid but keeps dout.
    send(2'b00, 8'h05);
    check_all("wr_addr_clears_txv");
    check8("wr_addr_clears_txv.dout_kept", dout, 8'hA5);

    // Async reset mid-cycle, no clock edge in between.
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // Early WR_DATA after reset must not land at address 0.
    send(2'b01, 8'h3C);
    send(2'b00, 8'h00);
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);
    check_all("no_write_without_addr");
    check8("no_write_without_addr.const", dout, 8'h00);

    // Reset coinciding with a WR_DATA strobe: no commit.
    do_reset();
    send(2'b00, 8'h20);
    send(2'b01, 8'h77);
    @(negedge clk);
    rx_din   = {2'b01, 8'hFF};
    rx_valid = 1'b1;
    rst      = 1'b1;
    model_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
    check_all("reset_during_write");
    send(2'b10, 8'h20);
    send(2'b11, 8'h00);
    check_all("reset_during_write.readback");
    check8("reset_during_write.const", dout, 8'h77);

    // Consecutive writes at the top address.
    do_reset();
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    check_all("top_addr");
`ifdef ADDR_AUTOINC_EN
    check8("top_addr.const", dout, 8'h11);
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);
    check8("wrap_addr.const", dout, 8'h22);
`else
    check8("top_addr.const", dout, 8'h22);
`endif

    // Back-to-back reads keep tx_valid high.
    send(2'b10, 8'h40);
    strobe(2'b11, 8'h00, 3);
    check_all("multi_cycle_read");

    // Randomized command stream against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      c  = 2'($urandom_range(0, 3));
      pl = 8'($urandom_range(0, 255));
      n  = ($urandom_range(0, 7) == 0) ? 2 : 1;
      strobe(c, pl, n);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      check_all("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
